npu_ctrl_stream: RTL and testbench

//  Next-generation NPU top-level control unit. Accepts a packetised init stream (instructions, scalar and

---
 rtl/npu_ctrl_stream.sv | 182 ++++++++++++++++++
 tb/tb_npu_ctrl_stream.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/npu_ctrl_stream.sv
// npu_ctrl_stream: NPU control unit. Steers the init stream into the memory regions,
// supervises execution against the core PC and streams results out with valid/ready.
//
// state | meaning
// IDLE  | waiting for an sop beat; ready_o high
// LOAD  | init beats being written to inst/scalar/vector regions
// COMP  | core executing; watching PC for last instruction, timeout running
// DONE  | result count latched; empty result set finishes here
// TRAN  | result beats streamed out under backpressure
module npu_ctrl_stream #(
  parameter int                    ADDR_WIDTH     = 16,
  parameter int                    PC_WIDTH       = 8,
  parameter logic [ADDR_WIDTH-1:0] SCALAR_BASE    = 16'h0100,
  parameter logic [ADDR_WIDTH-1:0] VECTOR_BASE    = 16'h0200,
  parameter logic [ADDR_WIDTH-1:0] VECTOR_UPPER   = 16'h0300,
  parameter int                    VMAX           = 8,
  parameter int                    VMAX_WIDTH     = $clog2(VMAX),
  parameter int                    TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  abort_i,
  input  logic                  valid_i,
  input  logic                  sop_i,
  input  logic                  eop_i,
  input  logic [ADDR_WIDTH-1:0] addr_in_i,
  output logic                  ready_o,
  output logic [ADDR_WIDTH-1:0] addr_out_o,
  output logic [2:0]            wen_init_o,
  input  logic [PC_WIDTH-1:0]   pc_current_i,
  output logic                  is_working_o,
  output logic                  complete_o,
  output logic [PC_WIDTH:0]     inst_count_o,
  input  logic [VMAX_WIDTH:0]   result_cnt_i,
  output logic                  result_ren_o,
  output logic [VMAX_WIDTH-1:0] result_raddr_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  sop_o,
  output logic                  eop_o,
  output logic                  trans_complete_o,
  output logic                  err_o,
  output logic [1:0]            err_code_o
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COMP, S_DONE, S_TRAN} state_t;

  localparam int                  TW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]       TMO_LOAD  = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [TW-1:0]       TMO_ONE   = TW'(1);
  localparam logic [PC_WIDTH:0]   INST_MAX  = {1'b1, {PC_WIDTH{1'b0}}};
  localparam logic [PC_WIDTH:0]   INST_ONE  = (PC_WIDTH+1)'(1);
  localparam logic [VMAX_WIDTH:0] CNT_ONE   = (VMAX_WIDTH+1)'(1);
  localparam logic [VMAX_WIDTH:0] CNT_MAX   = (VMAX_WIDTH+1)'(VMAX);
  localparam logic [VMAX_WIDTH-1:0] RADDR_ONE = VMAX_WIDTH'(1);

  state_t                r_state, w_next;
  logic [PC_WIDTH:0]     r_inst_count;
  logic [TW-1:0]         r_tmo;
  logic [VMAX_WIDTH:0]   r_cnt_q, r_issued, r_out_idx;
  logic [VMAX_WIDTH-1:0] r_raddr;
  logic                  r_valid;
  logic [1:0]            r_err_code;

  logic                  w_beat, w_sop_acc;
  logic                  w_in_inst, w_in_scalar, w_in_vector;
  logic                  w_inst_full, w_inst_wr;
  logic [1:0]            w_beat_code;
  logic [PC_WIDTH:0]     w_inst_next;
  logic                  w_complete, w_tmo_fire;
  logic [VMAX_WIDTH:0]   w_cnt_in;
  logic                  w_ren, w_hs, w_eop_idx, w_last_hs;

  // sop beat is accepted from IDLE and written in the same cycle as LOAD beats
  assign w_beat      = valid_i && !abort_i &&
                       ((r_state == S_LOAD) || ((r_state == S_IDLE) && sop_i));
  assign w_sop_acc   = w_beat && (r_state == S_IDLE);
  assign w_in_inst   = addr_in_i < SCALAR_BASE;
  assign w_in_scalar = !w_in_inst && (addr_in_i < VECTOR_BASE);
  assign w_in_vector = !w_in_inst && !w_in_scalar && (addr_in_i < VECTOR_UPPER);
  assign w_inst_full = (r_inst_count == INST_MAX);
  assign w_inst_wr   = w_beat && w_in_inst && !w_inst_full;
  assign w_inst_next = w_inst_wr ? (r_inst_count + INST_ONE) : r_inst_count;
  assign w_beat_code = !w_beat ? 2'b00 :
                       !(w_in_inst || w_in_scalar || w_in_vector) ? 2'b01 :
                       (w_in_inst && w_inst_full) ? 2'b10 : 2'b00;

  assign w_complete  = (r_state == S_COMP) &&
                       ({1'b0, pc_current_i} == (r_inst_count - INST_ONE));
  assign w_tmo_fire  = (TIMEOUT_CYCLES != 0) && (r_state == S_COMP) &&
                       (r_tmo == '0) && !w_complete;

  assign w_cnt_in    = (result_cnt_i > CNT_MAX) ? CNT_MAX : result_cnt_i;
  assign w_ren       = (r_state == S_TRAN) && (r_issued < r_cnt_q) && (!r_valid || ready_i);
  assign w_hs        = r_valid && ready_i;
  assign w_eop_idx   = (r_out_idx == (r_cnt_q - CNT_ONE));
  assign w_last_hs   = (r_state == S_TRAN) && w_hs && w_eop_idx;

  assign addr_out_o  = addr_in_i;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (abort_i) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (valid_i && sop_i)
                  w_next = !eop_i ? S_LOAD : ((w_inst_next != '0) ? S_COMP : S_DONE);
        S_LOAD: if (valid_i && eop_i)
                  w_next = (w_inst_next != '0) ? S_COMP : S_DONE;
        S_COMP: if (w_complete)      w_next = S_DONE;
                else if (w_tmo_fire) w_next = S_IDLE;
        S_DONE: w_next = (w_cnt_in == '0) ? S_IDLE : S_TRAN;
        S_TRAN: if (w_last_hs) w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    wen_init_o = 3'b000;
    if (w_beat) begin
      if (w_inst_wr)        wen_init_o = 3'b001;
      else if (w_in_scalar) wen_init_o = 3'b010;
      else if (w_in_vector) wen_init_o = 3'b100;
    end
    ready_o          = (r_state == S_IDLE);
    is_working_o     = (r_state == S_COMP);
    complete_o       = w_complete;
    trans_complete_o = !abort_i && (((r_state == S_DONE) && (w_cnt_in == '0)) || w_last_hs);
    valid_o          = r_valid;
    sop_o            = r_valid && (r_out_idx == '0);
    eop_o            = r_valid && w_eop_idx;
    result_ren_o     = w_ren;
    result_raddr_o   = r_raddr;
    inst_count_o     = r_inst_count;
    err_code_o       = r_err_code;
    err_o            = (r_err_code != 2'b00);
  end

  always_ff @(posedge clk) begin
    if (rst || abort_i) begin
      r_inst_count <= '0;
      r_tmo        <= TMO_LOAD;
      r_cnt_q      <= '0;
      r_issued     <= '0;
      r_out_idx    <= '0;
      r_raddr      <= '0;
      r_valid      <= 1'b0;
      if (rst) r_err_code <= 2'b00;
    end else begin
      if (w_next == S_IDLE) r_inst_count <= '0;
      else if (w_inst_wr)   r_inst_count <= w_inst_next;

      r_tmo <= (r_state == S_COMP) ? (r_tmo - TMO_ONE) : TMO_LOAD;

      if (r_state == S_DONE) begin
        r_cnt_q  <= w_cnt_in;
        r_issued <= '0;
      end else if (w_ren) begin
        r_issued  <= r_issued + CNT_ONE;
        r_out_idx <= r_issued;
      end

      if ((r_state == S_DONE) || (w_next == S_IDLE)) r_raddr <= '0;
      else if (w_ren)                                r_raddr <= r_raddr + RADDR_ONE;

      if (w_ren)     r_valid <= 1'b1;
      else if (w_hs) r_valid <= 1'b0;

      // first error sticks; an accepted sop restarts reporting with its own beat
      if (w_sop_acc)                r_err_code <= w_beat_code;
      else if (r_err_code == 2'b00) r_err_code <= w_tmo_fire ? 2'b11 : w_beat_code;
    end
  end

endmodule

// File: tb/tb_npu_ctrl_stream.sv
// tb_npu_ctrl_stream: directed scenarios for npu_ctrl_stream with a 1-cycle-latency
// result buffer model; expectations are hand-derived constants.
module tb_npu_ctrl_stream;
  logic        clk = 1'b0;
  logic        rst = 1'b1, abort_i = 1'b0;
  logic        valid_i = 1'b0, sop_i = 1'b0, eop_i = 1'b0;
  logic [15:0] addr_in_i = '0;
  logic        ready_o;
  logic [15:0] addr_out_o;
  logic [2:0]  wen_init_o;
  logic [7:0]  pc_current_i = '0;
  logic        is_working_o, complete_o;
  logic [8:0]  inst_count_o;
  logic [3:0]  result_cnt_i = '0;
  logic        result_ren_o;
  logic [2:0]  result_raddr_o;
  logic        valid_o, ready_i = 1'b1, sop_o, eop_o, trans_complete_o, err_o;
  logic [1:0]  err_code_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  npu_ctrl_stream #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .abort_i(abort_i), .valid_i(valid_i), .sop_i(sop_i), .eop_i(eop_i),
    .addr_in_i(addr_in_i), .ready_o(ready_o), .addr_out_o(addr_out_o), .wen_init_o(wen_init_o),
    .pc_current_i(pc_current_i), .is_working_o(is_working_o), .complete_o(complete_o),
    .inst_count_o(inst_count_o), .result_cnt_i(result_cnt_i), .result_ren_o(result_ren_o),
    .result_raddr_o(result_raddr_o), .valid_o(valid_o), .ready_i(ready_i), .sop_o(sop_o),
    .eop_o(eop_o), .trans_complete_o(trans_complete_o), .err_o(err_o), .err_code_o(err_code_o)
  );

  // result buffer: registered read, holds data while not read
  logic [7:0] buf_q = '0;
  always @(posedge clk)
    if (result_ren_o) buf_q <= 8'hA0 + {5'd0, result_raddr_o};

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic set_beat(input logic [15:0] a, input logic s, input logic e);
    valid_i = 1'b1; sop_i = s; eop_i = e; addr_in_i = a;
  endtask

  task automatic idle_in;
    valid_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0; addr_in_i = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1; idle_in();
    tick(); tick(); #1;
    total++; if ({ready_o, valid_o, sop_o, eop_o, result_ren_o, complete_o, trans_complete_o, err_o, is_working_o} !== 9'b1_0000_0000) begin
      bad++; $display("FAIL reset_flags: got %b want 100000000", {ready_o, valid_o, sop_o, eop_o, result_ren_o, complete_o, trans_complete_o, err_o, is_working_o}); end
    total++; if (err_code_o !== 2'b00) begin bad++; $display("FAIL reset_err_code: got %b want 00", err_code_o); end
    total++; if (result_raddr_o !== 3'd0) begin bad++; $display("FAIL reset_raddr: got %0d want 0", result_raddr_o); end
    total++; if (inst_count_o !== 9'd0) begin bad++; $display("FAIL reset_inst_count: got %0d want 0", inst_count_o); end
    total++; if (wen_init_o !== 3'b000) begin bad++; $display("FAIL reset_wen: got %b want 000", wen_init_o); end
    rst = 1'b0;
  endtask

  task automatic test_load_comp;
    logic [15:0] addrs [7] = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0100, 16'h0101, 16'h0200};
    logic [2:0]  wens  [7] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b010, 3'b100};
    result_cnt_i = 4'd3; ready_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick(); set_beat(addrs[i], i == 0, i == 6); #1;
      total++; if (wen_init_o !== wens[i]) begin bad++; $display("FAIL load_wen[%0d]: got %b want %b", i, wen_init_o, wens[i]); end
      total++; if (addr_out_o !== addrs[i]) begin bad++; $display("FAIL load_addr_out[%0d]: got %h want %h", i, addr_out_o, addrs[i]); end
    end
    tick(); idle_in(); pc_current_i = 8'd0; #1;
    total++; if (is_working_o !== 1'b1) begin bad++; $display("FAIL comp_working: got %b want 1", is_working_o); end
    total++; if (inst_count_o !== 9'd4) begin bad++; $display("FAIL comp_inst_count: got %0d want 4", inst_count_o); end
    total++; if (complete_o !== 1'b0) begin bad++; $display("FAIL comp_pc0: got %b want 0", complete_o); end
    for (int p = 1; p < 4; p++) begin
      tick(); pc_current_i = 8'(p); #1;
      total++; if (complete_o !== (p == 3)) begin bad++; $display("FAIL comp_pc%0d: got %b want %b", p, complete_o, p == 3); end
    end
    tick(); #1;
    total++; if ({is_working_o, complete_o, trans_complete_o} !== 3'b000) begin
      bad++; $display("FAIL done_flags: got %b want 000", {is_working_o, complete_o, trans_complete_o}); end
  endtask

  task automatic test_stream_full;
    logic [7:0] dq [$];
    logic       sq [$];
    logic       eq [$];
    logic [2:0] rq [$];
    int cq [$];
    int tc = 0;
    bit done = 0;
    for (int c = 0; c < 30 && !done; c++) begin
      tick(); ready_i = 1'b1; #1;
      if (result_ren_o) rq.push_back(result_raddr_o);
      if (valid_o && ready_i) begin dq.push_back(buf_q); sq.push_back(sop_o); eq.push_back(eop_o); cq.push_back(c); end
      if (trans_complete_o) tc++;
      if (ready_o) done = 1;
    end
    total++; if (!done) begin bad++; $display("FAIL stream_timeout: got busy want idle within 30 cycles"); end
    total++; if (dq.size() !== 3) begin bad++; $display("FAIL stream_beats: got %0d want 3", dq.size()); end
    total++; if (rq.size() !== 3) begin bad++; $display("FAIL stream_reads: got %0d want 3", rq.size()); end
    for (int i = 0; i < rq.size(); i++) begin
      total++; if (rq[i] !== 3'(i)) begin bad++; $display("FAIL stream_raddr[%0d]: got %0d want %0d", i, rq[i], i); end
    end
    for (int i = 0; i < dq.size(); i++) begin
      total++; if (dq[i] !== 8'(8'hA0 + i)) begin bad++; $display("FAIL stream_data[%0d]: got %h want %h", i, dq[i], 8'(8'hA0 + i)); end
      total++; if ({sq[i], eq[i]} !== {i == 0, i == 2}) begin bad++; $display("FAIL stream_sop_eop[%0d]: got %b want %b", i, {sq[i], eq[i]}, {i == 0, i == 2}); end
    end
    if (cq.size() == 3) begin
      total++; if (cq[2] - cq[0] !== 2) begin bad++; $display("FAIL stream_b2b: got span %0d want 2", cq[2] - cq[0]); end
    end
    total++; if (tc !== 1) begin bad++; $display("FAIL stream_tc_count: got %0d want 1", tc); end
  endtask

  task automatic test_backpressure;
    logic [7:0] dq [$];
    int hs = 0, stall = 2, stalled = 0, rens = 0;
    bit done = 0;
    tick(); set_beat(16'h0000, 1'b1, 1'b1); pc_current_i = 8'd0; result_cnt_i = 4'd3; ready_i = 1'b1; #1;
    total++; if (wen_init_o !== 3'b001) begin bad++; $display("FAIL bp_one_beat_wen: got %b want 001", wen_init_o); end
    tick(); idle_in(); #1;
    total++; if ({is_working_o, complete_o, inst_count_o} !== {2'b11, 9'd1}) begin
      bad++; $display("FAIL bp_one_beat_comp: got %b want 11000000001", {is_working_o, complete_o, inst_count_o}); end
    tick();
    for (int c = 0; c < 30 && !done; c++) begin
      tick();
      ready_i = !(valid_o && hs == 1 && stall > 0);
      if (!ready_i) stall--;
      #1;
      if (result_ren_o) rens++;
      if (valid_o && !ready_i) begin
        stalled++;
        total++; if ({buf_q, sop_o, eop_o} !== {8'hA1, 2'b00}) begin bad++; $display("FAIL bp_hold: got %h want %h", {buf_q, sop_o, eop_o}, {8'hA1, 2'b00}); end
      end
      if (valid_o && ready_i) begin dq.push_back(buf_q); hs++; end
      if (ready_o) done = 1;
    end
    ready_i = 1'b1;
    total++; if (!done) begin bad++; $display("FAIL bp_timeout: got busy want idle within 30 cycles"); end
    total++; if (stalled !== 2) begin bad++; $display("FAIL bp_stall_cycles: got %0d want 2", stalled); end
    total++; if (rens !== 3) begin bad++; $display("FAIL bp_reads: got %0d want 3", rens); end
    total++; if (dq.size() !== 3) begin bad++; $display("FAIL bp_beats: got %0d want 3", dq.size()); end
    for (int i = 0; i < dq.size(); i++) begin
      total++; if (dq[i] !== 8'(8'hA0 + i)) begin bad++; $display("FAIL bp_data[%0d]: got %h want %h", i, dq[i], 8'(8'hA0 + i)); end
    end
  endtask

  task automatic test_bad_addr;
    result_cnt_i = 4'd0; pc_current_i = 8'd0;
    tick(); set_beat(16'h0000, 1'b1, 1'b0); #1;
    total++; if (wen_init_o !== 3'b001) begin bad++; $display("FAIL bad_first_wen: got %b want 001", wen_init_o); end
    tick(); set_beat(16'h0350, 1'b0, 1'b0); #1;
    total++; if (wen_init_o !== 3'b000) begin bad++; $display("FAIL bad_addr_wen: got %b want 000", wen_init_o); end
    tick(); set_beat(16'h0101, 1'b0, 1'b1); #1;
    total++; if ({err_o, err_code_o} !== 3'b101) begin bad++; $display("FAIL bad_addr_err: got %b want 101", {err_o, err_code_o}); end
    total++; if (wen_init_o !== 3'b010) begin bad++; $display("FAIL bad_continue_wen: got %b want 010", wen_init_o); end
    tick(); idle_in(); #1;
    total++; if (complete_o !== 1'b1) begin bad++; $display("FAIL bad_complete: got %b want 1", complete_o); end
    tick(); #1;
    total++; if ({trans_complete_o, valid_o} !== 2'b10) begin bad++; $display("FAIL bad_done_tc: got %b want 10", {trans_complete_o, valid_o}); end
    tick(); #1;
    total++; if ({ready_o, err_o, err_code_o} !== 4'b1101) begin bad++; $display("FAIL bad_err_sticky: got %b want 1101", {ready_o, err_o, err_code_o}); end
  endtask

  task automatic test_zero_len;
    result_cnt_i = 4'd0;
    tick(); set_beat(16'h0100, 1'b1, 1'b0); #1;
    total++; if (wen_init_o !== 3'b010) begin bad++; $display("FAIL zl_wen0: got %b want 010", wen_init_o); end
    tick(); set_beat(16'h0101, 1'b0, 1'b1); #1;
    total++; if ({err_o, err_code_o} !== 3'b000) begin bad++; $display("FAIL zl_err_cleared: got %b want 000", {err_o, err_code_o}); end
    tick(); idle_in(); #1;
    total++; if ({is_working_o, trans_complete_o, valid_o, inst_count_o} !== {3'b010, 9'd0}) begin
      bad++; $display("FAIL zl_done: got %b want 010000000000", {is_working_o, trans_complete_o, valid_o, inst_count_o}); end
    tick(); #1;
    total++; if ({ready_o, trans_complete_o, valid_o} !== 3'b100) begin bad++; $display("FAIL zl_idle: got %b want 100", {ready_o, trans_complete_o, valid_o}); end
  endtask

  task automatic test_overflow;
    result_cnt_i = 4'd0;
    tick(); set_beat(16'h0000, 1'b1, 1'b0);
    for (int i = 1; i < 256; i++) begin tick(); set_beat(16'(i), 1'b0, 1'b0); end
    tick(); set_beat(16'h0005, 1'b0, 1'b0); #1;
    total++; if (wen_init_o !== 3'b000) begin bad++; $display("FAIL ovf_wen: got %b want 000", wen_init_o); end
    total++; if (inst_count_o !== 9'd256) begin bad++; $display("FAIL ovf_count: got %0d want 256", inst_count_o); end
    tick(); set_beat(16'h0100, 1'b0, 1'b1); pc_current_i = 8'd255; #1;
    total++; if ({err_o, err_code_o} !== 3'b110) begin bad++; $display("FAIL ovf_err: got %b want 110", {err_o, err_code_o}); end
    tick(); idle_in(); #1;
    total++; if ({is_working_o, complete_o, inst_count_o} !== {2'b11, 9'd256}) begin
      bad++; $display("FAIL ovf_complete: got %b want 11100000000", {is_working_o, complete_o, inst_count_o}); end
    tick(); tick(); #1;
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL ovf_idle: got %b want 1", ready_o); end
  endtask

  task automatic test_timeout;
    int cyc = 0;
    bit done = 0;
    tick(); set_beat(16'h0000, 1'b1, 1'b1); pc_current_i = 8'd5; #1;
    tick(); idle_in(); #1;
    for (int c = 0; c < 40 && !done; c++) begin
      if (is_working_o) cyc++; else done = 1;
      if (!done) tick();
    end
    total++; if (!done) begin bad++; $display("FAIL tmo_stuck: got working want idle within 40 cycles"); end
    total++; if (cyc !== 16) begin bad++; $display("FAIL tmo_cycles: got %0d want 16", cyc); end
    total++; if ({ready_o, err_o, err_code_o, trans_complete_o} !== 5'b11110) begin
      bad++; $display("FAIL tmo_err: got %b want 11110", {ready_o, err_o, err_code_o, trans_complete_o}); end
  endtask

  task automatic test_abort;
    result_cnt_i = 4'd3; pc_current_i = 8'd0; ready_i = 1'b0;
    tick(); set_beat(16'h0000, 1'b1, 1'b0);
    tick(); set_beat(16'h0400, 1'b0, 1'b1); #1;
    total++; if (wen_init_o !== 3'b000) begin bad++; $display("FAIL ab_bad_wen: got %b want 000", wen_init_o); end
    tick(); idle_in(); #1;
    total++; if (complete_o !== 1'b1) begin bad++; $display("FAIL ab_complete: got %b want 1", complete_o); end
    tick(); tick(); tick(); #1;
    total++; if ({valid_o, sop_o} !== 2'b11) begin bad++; $display("FAIL ab_beat0_valid: got %b want 11", {valid_o, sop_o}); end
    tick(); abort_i = 1'b1;
    tick(); abort_i = 1'b0; #1;
    total++; if ({valid_o, ready_o, is_working_o} !== 3'b010) begin bad++; $display("FAIL ab_idle: got %b want 010", {valid_o, ready_o, is_working_o}); end
    total++; if ({result_raddr_o, inst_count_o} !== 12'd0) begin bad++; $display("FAIL ab_counters: got %h want 000", {result_raddr_o, inst_count_o}); end
    total++; if ({err_o, err_code_o} !== 3'b101) begin bad++; $display("FAIL ab_err_kept: got %b want 101", {err_o, err_code_o}); end
    tick(); #1;
    total++; if ({valid_o, result_ren_o} !== 2'b00) begin bad++; $display("FAIL ab_no_resume: got %b want 00", {valid_o, result_ren_o}); end
    ready_i = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200us");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load_comp();
    test_stream_full();
    test_backpressure();
    test_bad_addr();
    test_zero_len();
    test_overflow();
    test_timeout();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
